// File: rtl/vga_pkg.sv
// Shared VGA frame-path definitions: active geometry, pixel and FIFO entry
// types, and the write-side input state encoding.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef logic [7:0] pixel_t;

    typedef struct packed {
        logic   sof;
        pixel_t pixel;
    } fifo_entry_t;

    typedef enum logic {
        WAIT_SOF,
        RUN
    } writer_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered storage, parameterised by depth (power of
// two) and entry type. Push is ignored when full, pop is ignored when empty;
// full is evaluated on the pre-pop occupancy.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter type         entry_t = fifo_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t wr_entry,
    input  logic   pop,
    output entry_t rd_entry,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    // Storage array write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_frame_writer.sv
// Grayscale frame writer: buffers a sof-qualified pixel stream in a FIFO and
// issues single-pixel SDRAM writes in raster order from a frame base address.
// Optional double buffering is enabled by defining FRAME_DBUF_EN, which
// alternates the base between 0 and FRAME_PIXELS and adds the frame_sel port.
module sdram_frame_writer
    import vga_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_W       = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [7:0]        sdram_wr_data,
    output logic              sdram_wr_enable,
    input  logic              sdram_waitrequest,
    input  logic              clear_err,
    output logic              frame_done,
    output logic              overflow,
    output logic              overrun
`ifdef FRAME_DBUF_EN
    ,
    output logic              frame_sel
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

    writer_state_e     state;
    writer_state_e     state_next;
    fifo_entry_t       in_entry;
    fifo_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              overflow_set;
    logic              overrun_set;
    logic              accept;
    logic              discard;
    logic              frame_last;
    logic              drop;
    logic [ADDR_W-1:0] pcnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] base;

    assign in_entry = '{sof: pix_sof, pixel: pix_data};

    pixel_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_entry (in_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Input state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    // Input FSM: resync on sof, push while running, abort the frame on a full FIFO.
    always_comb begin
        state_next   = state;
        push         = 1'b0;
        overflow_set = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    if (fifo_full) begin
                        overflow_set = 1'b1;
                    end else begin
                        push       = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (pix_valid) begin
                    if (fifo_full) begin
                        overflow_set = 1'b1;
                        state_next   = WAIT_SOF;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_next = WAIT_SOF;
        endcase
    end

    // Write side: present the FIFO head, or silently drop non-sof entries past frame end.
    always_comb begin
        discard         = !fifo_empty && drop && !head.sof;
        sdram_wr_enable = !fifo_empty && !discard;
        accept          = sdram_wr_enable && !sdram_waitrequest;
        pop             = accept || discard;
        overrun_set     = discard;
        idx             = head.sof ? '0 : pcnt;
        frame_last      = accept && (idx == LAST_IDX);
        sdram_wr_addr   = sdram_wr_enable ? (base + idx) : '0;
        sdram_wr_data   = sdram_wr_enable ? head.pixel : '0;
    end

    // Pixel counter, end-of-frame drop condition and frame_done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt       <= '0;
            drop       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_last;
            if (frame_last) begin
                pcnt <= '0;
                drop <= 1'b1;
            end else if (accept) begin
                pcnt <= idx + ADDR_W'(1);
                drop <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error takes priority over clear_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef FRAME_DBUF_EN
    localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FRAME_PIXELS);

    // Swap buffers on each completed frame and report the one just finished.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base      <= '0;
            frame_sel <= 1'b0;
        end else if (frame_last) begin
            frame_sel <= (base != '0);
            base      <= (base == '0) ? BUF1_BASE : '0;
        end
    end
`else
    assign base = '0;
`endif

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed scoreboard bench for sdram_frame_writer with a 4-pixel frame and a
// 4-entry FIFO; also builds with FRAME_DBUF_EN to cover double buffering.
module tb_sdram_frame_writer;

    localparam int unsigned FP    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic [AW-1:0] sdram_wr_addr;
    logic [7:0]    sdram_wr_data;
    logic          sdram_wr_enable;
    logic          sdram_waitrequest = 1'b0;
    logic          clear_err = 1'b0;
    logic          frame_done;
    logic          overflow;
    logic          overrun;
`ifdef FRAME_DBUF_EN
    logic          frame_sel;
`endif

    sdram_frame_writer #(
        .FRAME_PIXELS (FP),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_sof           (pix_sof),
        .sdram_wr_addr     (sdram_wr_addr),
        .sdram_wr_data     (sdram_wr_data),
        .sdram_wr_enable   (sdram_wr_enable),
        .sdram_waitrequest (sdram_waitrequest),
        .clear_err         (clear_err),
        .frame_done        (frame_done),
        .overflow          (overflow),
        .overrun           (overrun)
`ifdef FRAME_DBUF_EN
        ,
        .frame_sel         (frame_sel)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  acc_cyc_q[$];
    int  total = 0;
    int  bad = 0;
    int  ncyc = 0;
    int  fd_cnt = 0;
    int  fd_cyc = -1;
    int  exp_fd = 0;
    bit  exp_buf = 1'b0;

    // Monitor: every accepted write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            ncyc++;
            if (sdram_wr_enable && !sdram_waitrequest) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_write: addr=%h data=%h required no write", sdram_wr_addr, sdram_wr_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert ({sdram_wr_addr, sdram_wr_data} === {e.addr, e.data}) else begin
                        bad++;
                        $error("FAIL write: addr=%h data=%h required addr=%h data=%h",
                               sdram_wr_addr, sdram_wr_data, e.addr, e.data);
                    end
                end
                acc_cyc_q.push_back(ncyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = ncyc;
            end
        end
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish, required completion");
    end

    function automatic logic [AW-1:0] addr_of(input int unsigned i);
`ifdef FRAME_DBUF_EN
        return AW'(exp_buf ? FP + i : i);
`else
        return AW'(i);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%h required=%h", tag, obs, req);
        end
    endtask

    // Drive one pixel for one cycle; optionally expect it written at frame index idx.
    task automatic send(input logic [7:0] d, input bit sof, input bit expw, input int unsigned idx);
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        if (expw) exp_q.push_back('{addr: addr_of(idx), data: d});
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || sdram_wr_enable) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (exp_q.size() == 0 && !sdram_wr_enable) else begin
            bad++;
            $error("FAIL %s drain: pending=%0d enable=%b required pending=0 enable=0",
                   tag, exp_q.size(), sdram_wr_enable);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frame_end(input string tag);
        exp_fd++;
`ifdef FRAME_DBUF_EN
        check({tag, "_frame_sel"}, 32'(frame_sel), 32'(exp_buf));
        exp_buf = ~exp_buf;
`endif
        check({tag, "_fd_cnt"}, 32'(fd_cnt), 32'(exp_fd));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_en",       32'(sdram_wr_enable), 32'd0);
        check("rst_addr",     32'(sdram_wr_addr),   32'd0);
        check("rst_data",     32'(sdram_wr_data),   32'd0);
        check("rst_fd",       32'(frame_done),      32'd0);
        check("rst_overflow", 32'(overflow),        32'd0);
        check("rst_overrun",  32'(overrun),         32'd0);
`ifdef FRAME_DBUF_EN
        check("rst_frame_sel", 32'(frame_sel), 32'd0);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Pixels before any sof are never written
        send(8'hA0, 1'b0, 1'b0, 0);
        send(8'hA1, 1'b0, 1'b0, 0);
        send(8'hA2, 1'b0, 1'b0, 0);
        drain("presof");

        // Full frame, no stalls: consecutive writes, frame_done one cycle later
        acc_cyc_q.delete();
        send(8'h10, 1'b1, 1'b1, 0);
        send(8'h11, 1'b0, 1'b1, 1);
        send(8'h12, 1'b0, 1'b1, 2);
        send(8'h13, 1'b0, 1'b1, 3);
        drain("frame1");
        check("f1_accepts", 32'(acc_cyc_q.size()), 32'd4);
        if (acc_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("f1_consecutive", 32'(acc_cyc_q[i] - acc_cyc_q[0]), 32'(i));
            end
            check("f1_done_latency", 32'(fd_cyc - acc_cyc_q[3]), 32'd1);
        end
        frame_end("f1");

        // Stall: interface holds while waitrequest is high, short frame after
        sdram_waitrequest = 1'b1;
        send(8'h20, 1'b1, 1'b1, 0);
        send(8'h21, 1'b0, 1'b1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", 32'({sdram_wr_enable, sdram_wr_addr, sdram_wr_data}),
                  32'({1'b1, addr_of(0), 8'h20}));
        end
        @(posedge clk);
        #1;
        sdram_waitrequest = 1'b0;
        drain("stall");
        check("stall_no_fd", 32'(fd_cnt), 32'(exp_fd));

        // Overflow: fill the FIFO under stall, then one more pixel
        sdram_waitrequest = 1'b1;
        send(8'h30, 1'b1, 1'b1, 0);
        send(8'h31, 1'b0, 1'b1, 1);
        send(8'h32, 1'b0, 1'b1, 2);
        send(8'h33, 1'b0, 1'b1, 3);
        check("ovf_before", 32'(overflow), 32'd0);
        send(8'h34, 1'b0, 1'b0, 0);
        check("ovf_set", 32'(overflow), 32'd1);
        send(8'h35, 1'b0, 1'b0, 0);
        sdram_waitrequest = 1'b0;
        drain("ovf");
        frame_end("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Overrun: fifth pixel of a 4-pixel frame is dropped
        send(8'h40, 1'b1, 1'b1, 0);
        send(8'h41, 1'b0, 1'b1, 1);
        send(8'h42, 1'b0, 1'b1, 2);
        send(8'h43, 1'b0, 1'b1, 3);
        send(8'h44, 1'b0, 1'b0, 0);
        drain("ovr");
        frame_end("ovr");
        check("ovr_set", 32'(overrun), 32'd1);
        send(8'h50, 1'b1, 1'b1, 0);
        drain("ovr_next");
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);

        // Overflow coinciding with clear_err: the set wins
        sdram_waitrequest = 1'b1;
        send(8'h60, 1'b1, 1'b1, 0);
        send(8'h61, 1'b0, 1'b1, 1);
        send(8'h62, 1'b0, 1'b1, 2);
        send(8'h63, 1'b0, 1'b1, 3);
        clear_err = 1'b1;
        send(8'h64, 1'b0, 1'b0, 0);
        clear_err = 1'b0;
        check("ovf_vs_clear", 32'(overflow), 32'd1);
        sdram_waitrequest = 1'b0;
        drain("ovf2");
        frame_end("ovf2");

        // Asynchronous reset mid-frame drops pending data immediately
        sdram_waitrequest = 1'b1;
        send(8'h70, 1'b1, 1'b0, 0);
        check("pre_reset_en", 32'(sdram_wr_enable), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_en", 32'(sdram_wr_enable), 32'd0);
        check("async_reset_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_buf = 1'b0;
        sdram_waitrequest = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_en", 32'(sdram_wr_enable), 32'd0);

        // Frame after reset starts at buffer 0
        send(8'h80, 1'b1, 1'b1, 0);
        send(8'h81, 1'b0, 1'b1, 1);
        send(8'h82, 1'b0, 1'b1, 2);
        send(8'h83, 1'b0, 1'b1, 3);
        drain("post_reset_frame");
        frame_end("post_reset_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
